fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers the returned instructions and presents them to the IF/ID register.
- Obeys the fetch stall from the hazard unit and accepts branch/jump redirects from decode/execute.
- Sits between imem and the decode stage, directly upstream of the hazard unit's D-stage register addresses.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef logic [31:0] Word;
    typedef logic        Signal;

    localparam Signal ENABLE  = 1'b1;
    localparam Signal DISABLE = 1'b0;

    localparam Word RESET_PC_DEFAULT = 32'h0000_0000;
    localparam Word PC_INC_DEFAULT   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO with flush. The head entry is visible on
// rdata whenever empty is low; a push while full is only accepted
// together with a pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under
// a credit limit, tags each request with its PC, buffers returned words and
// presents the buffer head to the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter Word RESET_PC  = RESET_PC_DEFAULT,
    parameter int  BUF_DEPTH = 4,
    parameter Word PC_INC    = PC_INC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  Signal stall_if,
    input  Signal redirect,
    input  Word   redirect_pc,
    output logic  imem_req,
    output Word   imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  Word   imem_rdata,
    output logic  id_valid,
    output Word   id_instr,
    output Word   id_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    Word           pc_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   in_use;
    logic [CW:0]   drop_calc;
    logic          gnt;
    logic          ibuf_push;
    logic          ibuf_pop;
    logic          ibuf_empty;
    logic          ibuf_full;
    logic          tag_empty;
    logic          tag_full;
    Word           tag_head;
    logic [63:0]   ibuf_head;

    // Credit depends on registered occupancy only, so a pop frees a slot
    // one cycle later and there is no path from the inputs to imem_req.
    assign in_use    = (CW+1)'(outstanding) + (CW+1)'(buf_count);
    assign imem_req  = (in_use < (CW+1)'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign gnt       = imem_req && imem_gnt;

    // Every in-flight request is dropped on redirect, including one granted
    // this cycle; a response arriving this cycle is discarded directly.
    assign drop_calc = (CW+1)'(outstanding) + (CW+1)'(gnt) - (CW+1)'(imem_rvalid);

    assign ibuf_push = imem_rvalid && (drop_cnt == '0) && (redirect == DISABLE);
    assign ibuf_pop  = id_valid && (stall_if == DISABLE) && (redirect == DISABLE);

    assign id_valid = !ibuf_empty;
    assign id_instr = id_valid ? ibuf_head[63:32] : '0;
    assign id_pc    = id_valid ? ibuf_head[31:0]  : '0;

    // PC of every granted request, popped as responses return (dropped or
    // not); its occupancy is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt),
        .wdata (pc_q),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .rdata (tag_head),
        .count (outstanding),
        .empty (tag_empty),
        .full  (tag_full)
    );

    // Returned instructions paired with their PC, flushed on redirect.
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ibuf_push),
        .wdata ({imem_rdata, tag_head}),
        .pop   (ibuf_pop),
        .flush (redirect == ENABLE),
        .rdata (ibuf_head),
        .count (buf_count),
        .empty (ibuf_empty),
        .full  (ibuf_full)
    );

    // PC advance and stale-response counter; redirect wins over grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect == ENABLE) begin
            pc_q     <= redirect_pc;
            drop_cnt <= drop_calc[CW-1:0];
        end else begin
            if (gnt) pc_q <= pc_q + PC_INC;
            if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Protocol checks on the imem handshake and internal occupancy.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_rvalid_idle:  assert (!(imem_rvalid && tag_empty));
            a_ibuf_ovf:     assert (!(ibuf_push && ibuf_full && !ibuf_pop));
            a_tag_ovf:      assert (!(gnt && tag_full && !imem_rvalid));
            a_drop_bound:   assert (drop_cnt <= outstanding);
            a_drop_undflow: assert (!((redirect == ENABLE) && drop_calc[CW]));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency imem model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic  clk;
    logic  rst_n;
    Signal stall_if;
    Signal redirect;
    Word   redirect_pc;
    logic  imem_req;
    Word   imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    Word   imem_rdata;
    logic  id_valid;
    Word   id_instr;
    Word   id_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc     = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (4),
        .PC_INC    (32'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_if    (stall_if),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic Word instr_of(Word a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // imem model: records grants, answers in order after lat cycles.
    typedef struct {
        Word addr;
        int  due;
    } mreq_t;
    mreq_t mq[$];

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat - 1});
        end
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    task automatic check(input string name, input Word act, input Word exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int l);
        rst_n    = 1'b0;
        stall_if = DISABLE;
        redirect = DISABLE;
        imem_gnt = 1'b1;
        repeat (2) step();
        lat   = l;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (id_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_head(input string name, input Word exp_pc);
        check({name, "_valid"}, 32'(id_valid), 32'd1);
        check({name, "_pc"}, id_pc, exp_pc);
        check({name, "_instr"}, id_instr, instr_of(exp_pc));
    endtask

    typedef struct {
        logic stall;
        logic exp_valid;
        Word  exp_pc;
        logic exp_req;
        Word  exp_addr;
    } vec_t;
    vec_t tbl[16];

    initial begin
        int n;
        rst_n       = 1'b0;
        stall_if    = DISABLE;
        redirect    = DISABLE;
        redirect_pc = '0;
        imem_gnt    = 1'b1;

        // Streaming with a 5-cycle stall while 0x8 is at the head.
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        tbl[2]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h08};
        tbl[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0C};
        tbl[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
        tbl[5]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h14};
        tbl[6]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h18};
        tbl[7]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h18};
        tbl[8]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h18};
        tbl[9]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h18};
        tbl[10] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h18};
        tbl[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
        tbl[12] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h20};
        tbl[13] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h24};
        tbl[14] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h28};
        tbl[15] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h2C};

        repeat (2) step();
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, 32'd0);
        lat   = 1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_pc", i), id_pc, tbl[i].exp_pc);
            check($sformatf("vec%0d_instr", i), id_instr,
                  tbl[i].exp_valid ? instr_of(tbl[i].exp_pc) : 32'd0);
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
            stall_if = tbl[i].stall;
            step();
        end
        stall_if = DISABLE;

        // Redirect with two requests in flight, latency 3.
        do_reset(3);
        step();
        step();
        imem_gnt    = 1'b0;
        redirect    = ENABLE;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = DISABLE;
        imem_gnt = 1'b1;
        check("t3_valid", 32'(id_valid), 32'd0);
        check("t3_addr", imem_addr, 32'h0000_0100);
        check("t3_req", 32'(imem_req), 32'd1);
        wait_valid(n);
        check("t3_wait", 32'(n), 32'd4);
        check_head("t3_first", 32'h0000_0100);
        step();
        check_head("t3_second", 32'h0000_0104);

        // Redirect coinciding with a grant and a response.
        do_reset(1);
        step();
        redirect    = ENABLE;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = DISABLE;
        check("t4_valid", 32'(id_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h0000_0200);
        wait_valid(n);
        check("t4_wait", 32'(n), 32'd2);
        check_head("t4_first", 32'h0000_0200);
        step();
        check_head("t4_second", 32'h0000_0204);

        // PC wrap at the top of the address space.
        do_reset(1);
        redirect    = ENABLE;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = DISABLE;
        check("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("t5_addr1", imem_addr, 32'h0000_0000);
        check("t5_valid", 32'(id_valid), 32'd0);
        step();
        check_head("t5_first", 32'hFFFF_FFFC);
        step();
        check_head("t5_wrap", 32'h0000_0000);

        // Reset asserted with three entries buffered.
        do_reset(1);
        stall_if = ENABLE;
        repeat (4) step();
        check_head("t6_pre", 32'h0000_0000);
        check("t6_pre_req", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(id_valid), 32'd0);
        check("t6_rst_pc", id_pc, 32'd0);
        check("t6_rst_addr", imem_addr, 32'd0);
        check("t6_rst_req", 32'(imem_req), 32'd1);
        stall_if = DISABLE;
        repeat (2) step();
        rst_n = 1'b1;
        check("t6_rel_req", 32'(imem_req), 32'd1);
        check("t6_rel_addr", imem_addr, 32'd0);
        wait_valid(n);
        check("t6_wait", 32'(n), 32'd2);
        check_head("t6_first", 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
